led_axi_write_ctrl: RTL and testbench
=====================================

Name: led_axi_write_ctrl

Overview:
AXI4-Lite write-channel slave front end for the LED peripheral. It sits directly upstream of the LED register user logic.
- Accepts AW and W beats in either order or together.
- Produces the single-cycle slv_reg_wren strobe, the captured axi_awaddr and aligned write data that the LED stage consumes.
- Returns the B response.
Read channel is out of scope and lives in a separate block.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, AXI address width; must match the LED stage's axi_awaddr width.

Ports:
S_AXI_ACLK  in  1  system clock, all logic on rising edge
S_AXI_ARESETN  in  1  synchronous, active-high reset (1 = reset, despite the name)
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  address valid
S_AXI_AWREADY  out  1  address ready
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes
S_AXI_WVALID  in  1  data valid
S_AXI_WREADY  out  1  data ready
S_AXI_BRESP  out  2  write response, always 2'b00
S_AXI_BVALID  out  1  response valid
S_AXI_BREADY  in  1  response ready
slv_reg_wren  out  1  one-cycle write strobe to the LED stage
axi_awaddr  out  C_S_AXI_ADDR_WIDTH  captured address, valid when slv_reg_wren=1
slv_wdata  out  C_S_AXI_DATA_WIDTH  captured data, valid when slv_reg_wren=1
slv_wstrb  out  C_S_AXI_DATA_WIDTH/8  captured strobes, valid when slv_reg_wren=1

Behaviour:
- FSM states: IDLE, HAVE_AW, HAVE_W, RESP. State register is the only control storage.
- READY signals are Moore outputs decoded from state; no combinational VALID-to-READY path.
  - IDLE: AWREADY=1, WREADY=1.
  - HAVE_AW: AWREADY=0, WREADY=1.
  - HAVE_W: AWREADY=1, WREADY=0.
  - RESP: both READY signals 0.
- AW handshake (AWVALID&&AWREADY) latches AWADDR. W handshake latches WDATA and WSTRB.
- Transitions:
  - IDLE + both handshakes in the same cycle -> RESP.
  - IDLE + AW only -> HAVE_AW.
  - IDLE + W only -> HAVE_W.
  - HAVE_AW + W handshake -> RESP.
  - HAVE_W + AW handshake -> RESP.
  - RESP + BREADY -> IDLE.
- Latency: if the completing handshake occurs in cycle N, then in cycle N+1:
  - slv_reg_wren=1 for exactly one cycle;
  - axi_awaddr, slv_wdata and slv_wstrb hold the captured values;
  - BVALID=1 and BRESP=2'b00.
- BVALID stays high until the BVALID&&BREADY cycle M, then drops at M+1. State returns to IDLE at M+1, so READY signals reassert at M+1.
- With BREADY tied high, the fastest accepted rate is one write every 2 cycles.
- axi_awaddr, slv_wdata and slv_wstrb hold their last captured values between writes; they change only on a handshake.
- No address decode or SLVERR. Every write gets OKAY; decode belongs to the downstream stage.
- Reset (S_AXI_ARESETN=1 at a clock edge):
  - state -> IDLE;
  - AWREADY, WREADY, BVALID, slv_reg_wren -> 0;
  - axi_awaddr, slv_wdata, slv_wstrb -> 0;
  - BRESP -> 0.
  While reset is held, AWREADY and WREADY are forced to 0.
- Reset mid-operation (HAVE_AW, HAVE_W or RESP): the transaction is discarded. No slv_reg_wren is issued and BVALID drops the next cycle.
- AWVALID or WVALID held high during RESP is not accepted until IDLE is re-entered.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, HAVE_AW=2'd1, HAVE_W=2'd2, RESP=2'd3);
  - RESP_OKAY=2'b00;
  - ADDR_LSB=2, the word offset the LED stage uses for decode.
- Single module; no sub-module is natural. A future read-channel block reuses the package.

Test Plan:
1. AWVALID and WVALID together in cycle N, AWADDR=0x0, WDATA=0x000000A5, WSTRB=4'hF, BREADY=1 -> in cycle N+1: slv_reg_wren=1 (one cycle), axi_awaddr=0, slv_wdata=0xA5, BVALID=1, BRESP=00.
2. AWADDR=0x4 at cycle 2, WDATA=0x3C at cycle 5 -> AWREADY=0/WREADY=1 during cycles 3-5; wren at cycle 6 with axi_awaddr=0x4 and slv_wdata=0x3C.
3. W first (WDATA=0xFF), then AW (AWADDR=0x0) two cycles later -> single wren pulse with slv_wdata=0xFF and axi_awaddr=0.
4. BREADY held low 4 cycles after BVALID while a second AW/W is presented -> BVALID stays high, no second handshake, exactly one wren pulse; second write is accepted the cycle after BREADY.
5. Reset asserted while in HAVE_AW -> next cycle all outputs are 0 and state is IDLE; a subsequent full write completes normally.
6. Two back-to-back writes with BREADY=1, data 0x01 then 0x02 -> two wren pulses 2 cycles apart, with slv_wdata=0x01 then 0x02.

Source files
------------

// File: rtl/led_axi_write_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_axi_write_ctrl_pkg
//   Shared definitions for the LED peripheral AXI4-Lite slave front ends.
//   This package holds the write FSM state encoding, the response code and
//   the word offset used by the downstream register decode. The read-channel
//   block is expected to import it as well.
// ---------------------------------------------------------------------------
package led_axi_write_ctrl_pkg;

  // Write-channel FSM encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2,
    RESP    = 2'd3
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // The LED stage decodes registers on 32-bit word boundaries.
  localparam int unsigned ADDR_LSB = 2;

  // Word index of a byte address, as seen by the register decode.
  function automatic int unsigned word_index(input logic [31:0] byte_addr);
    return int'(byte_addr >> ADDR_LSB);
  endfunction

endpackage : led_axi_write_ctrl_pkg

// File: rtl/led_axi_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_axi_write_ctrl_if
//   AXI4-Lite write channels (AW, W, B) between a bus master and the LED
//   write front end.
//   master modport : drives AW/W payload and VALIDs, and BREADY
//   slave  modport : drives AWREADY, WREADY, BRESP and BVALID
// ---------------------------------------------------------------------------
interface led_axi_write_ctrl_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  import led_axi_write_ctrl_pkg::*;

  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY
  );

endinterface : led_axi_write_ctrl_if

// File: rtl/led_axi_write_ctrl.sv
// ---------------------------------------------------------------------------
// led_axi_write_ctrl
//   AXI4-Lite write-channel slave for the LED peripheral. It accepts AW and W
//   in either order or together, then issues a single-cycle write strobe with
//   the captured address/data/strobes to the LED register stage, and returns
//   an OKAY response on B. Only a 32-bit data width is supported.
//
//   Ports
//     S_AXI_ACLK     : clock, rising edge
//     S_AXI_ARESETN  : synchronous reset, active HIGH despite the name
//     s_axi          : AW/W/B channels (slave modport)
//     slv_reg_wren   : one-cycle write strobe to the LED stage
//     axi_awaddr     : captured write address
//     slv_wdata      : captured write data
//     slv_wstrb      : captured byte strobes
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting for AW and/or W, both READYs high
//   HAVE_AW | address captured, waiting for W
//   HAVE_W  | data captured, waiting for AW
//   RESP    | write issued, BVALID high until BREADY
// ---------------------------------------------------------------------------
module led_axi_write_ctrl
  import led_axi_write_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  led_axi_write_ctrl_if.slave               s_axi,
  output logic                              slv_reg_wren,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_wdata,
  output logic [(C_S_AXI_DATA_WIDTH/8)-1:0] slv_wstrb
);

  wr_state_e state_q, state_d;

  logic awready, wready, bvalid;
  logic aw_hs, w_hs;
  logic wr_done;

  logic                              wren_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] wstrb_q;

  // Protection bits carry no meaning for the LED registers.
  logic unused_awprot;
  assign unused_awprot = ^s_axi.S_AXI_AWPROT;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    aw_hs   = 1'b0;
    w_hs    = 1'b0;
    wr_done = 1'b0;

    case (state_q)
      IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
      end
      HAVE_AW: wready  = 1'b1;
      HAVE_W:  awready = 1'b1;
      RESP:    bvalid  = 1'b1;
      default: ;
    endcase

    // Keep the bus stalled while reset is held so nothing is half-accepted.
    if (S_AXI_ARESETN) begin
      awready = 1'b0;
      wready  = 1'b0;
    end

    aw_hs = s_axi.S_AXI_AWVALID && awready;
    w_hs  = s_axi.S_AXI_WVALID && wready;

    case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) begin
          state_d = RESP;
          wr_done = 1'b1;
        end else if (aw_hs) begin
          state_d = HAVE_AW;
        end else if (w_hs) begin
          state_d = HAVE_W;
        end
      end
      HAVE_AW: begin
        if (w_hs) begin
          state_d = RESP;
          wr_done = 1'b1;
        end
      end
      HAVE_W: begin
        if (aw_hs) begin
          state_d = RESP;
          wr_done = 1'b1;
        end
      end
      RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe and payload are registered so they line up with the first RESP
  // cycle; payload holds between writes and only moves on a handshake.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESETN) begin
      wren_q   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      wren_q <= wr_done;
      if (aw_hs) begin
        awaddr_q <= s_axi.S_AXI_AWADDR;
      end
      if (w_hs) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = RESP_OKAY;

  assign slv_reg_wren = wren_q;
  assign axi_awaddr   = awaddr_q;
  assign slv_wdata    = wdata_q;
  assign slv_wstrb    = wstrb_q;

endmodule : led_axi_write_ctrl

// File: tb/tb_led_axi_write_ctrl.sv
module tb_led_axi_write_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_axi_write_ctrl_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axi_if ();

  logic        wren;
  logic [3:0]  awaddr_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;

  led_axi_write_ctrl #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst),
    .s_axi         (axi_if.slave),
    .slv_reg_wren  (wren),
    .axi_awaddr    (awaddr_o),
    .slv_wdata     (wdata_o),
    .slv_wstrb     (wstrb_o)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t sb_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   wren_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (wren === 1'b1) begin
      wren_cnt++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_wren", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_addr", {28'd0, awaddr_o}, {28'd0, e.addr});
        check("sb_data", wdata_o, e.data);
        check("sb_strb", {28'd0, wstrb_o}, {28'd0, e.strb});
        check("sb_bvalid", {31'd0, axi_if.S_AXI_BVALID}, 32'd1);
        check("sb_bresp", {30'd0, axi_if.S_AXI_BRESP}, 32'd0);
      end
    end
  end

  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.addr = a; e.data = d; e.strb = s;
    sb_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    axi_if.S_AXI_AWADDR  = '0;
    axi_if.S_AXI_AWPROT  = '0;
    axi_if.S_AXI_AWVALID = 1'b0;
    axi_if.S_AXI_WDATA   = '0;
    axi_if.S_AXI_WSTRB   = '0;
    axi_if.S_AXI_WVALID  = 1'b0;
    axi_if.S_AXI_BREADY  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'd0, axi_if.S_AXI_AWREADY}, 32'd0);
    check("rst_wready", {31'd0, axi_if.S_AXI_WREADY}, 32'd0);
    check("rst_bvalid", {31'd0, axi_if.S_AXI_BVALID}, 32'd0);
    check("rst_wren", {31'd0, wren}, 32'd0);
    check("rst_awaddr", {28'd0, awaddr_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    drv_edge();
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", {31'd0, axi_if.S_AXI_AWREADY}, 32'd1);
    check("idle_wready", {31'd0, axi_if.S_AXI_WREADY}, 32'd1);

    // 1: AW and W together
    drv_edge();
    axi_if.S_AXI_AWADDR = 4'h0; axi_if.S_AXI_AWVALID = 1'b1;
    axi_if.S_AXI_WDATA = 32'h0000_00A5; axi_if.S_AXI_WSTRB = 4'hF; axi_if.S_AXI_WVALID = 1'b1;
    push(4'h0, 32'h0000_00A5, 4'hF);
    drv_edge();
    axi_if.S_AXI_AWVALID = 1'b0; axi_if.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    check("t1_wren", {31'd0, wren}, 32'd1);
    check("t1_wdata", wdata_o, 32'h0000_00A5);
    check("t1_bvalid", {31'd0, axi_if.S_AXI_BVALID}, 32'd1);
    check("t1_awready_resp", {31'd0, axi_if.S_AXI_AWREADY}, 32'd0);
    @(negedge clk);
    check("t1_wren_one_cycle", {31'd0, wren}, 32'd0);
    check("t1_bvalid_drop", {31'd0, axi_if.S_AXI_BVALID}, 32'd0);
    check("t1_awready_back", {31'd0, axi_if.S_AXI_AWREADY}, 32'd1);

    // 2: AW first, W three cycles later
    drv_edge();
    axi_if.S_AXI_AWADDR = 4'h4; axi_if.S_AXI_AWVALID = 1'b1;
    drv_edge();
    axi_if.S_AXI_AWVALID = 1'b0; axi_if.S_AXI_AWADDR = 4'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_awready_low", {31'd0, axi_if.S_AXI_AWREADY}, 32'd0);
      check("t2_wready_high", {31'd0, axi_if.S_AXI_WREADY}, 32'd1);
      check("t2_no_wren", {31'd0, wren}, 32'd0);
      if (i < 2) drv_edge();
    end
    drv_edge();
    axi_if.S_AXI_WDATA = 32'h0000_003C; axi_if.S_AXI_WSTRB = 4'hF; axi_if.S_AXI_WVALID = 1'b1;
    push(4'h4, 32'h0000_003C, 4'hF);
    drv_edge();
    axi_if.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    check("t2_wren", {31'd0, wren}, 32'd1);
    check("t2_awaddr", {28'd0, awaddr_o}, 32'h4);
    @(negedge clk);
    check("t2_awaddr_hold", {28'd0, awaddr_o}, 32'h4);

    // 3: W first, AW two cycles later
    drv_edge();
    axi_if.S_AXI_WDATA = 32'h0000_00FF; axi_if.S_AXI_WSTRB = 4'h3; axi_if.S_AXI_WVALID = 1'b1;
    drv_edge();
    axi_if.S_AXI_WVALID = 1'b0; axi_if.S_AXI_WDATA = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t3_awready_high", {31'd0, axi_if.S_AXI_AWREADY}, 32'd1);
    check("t3_wready_low", {31'd0, axi_if.S_AXI_WREADY}, 32'd0);
    drv_edge();
    axi_if.S_AXI_AWADDR = 4'h0; axi_if.S_AXI_AWVALID = 1'b1;
    push(4'h0, 32'h0000_00FF, 4'h3);
    drv_edge();
    axi_if.S_AXI_AWVALID = 1'b0;
    @(negedge clk);
    check("t3_wren", {31'd0, wren}, 32'd1);
    check("t3_wdata", wdata_o, 32'h0000_00FF);
    @(negedge clk);

    // 4: BREADY low while a second write is presented
    drv_edge();
    axi_if.S_AXI_BREADY = 1'b0;
    axi_if.S_AXI_AWADDR = 4'h8; axi_if.S_AXI_AWVALID = 1'b1;
    axi_if.S_AXI_WDATA = 32'h0000_0011; axi_if.S_AXI_WSTRB = 4'hF; axi_if.S_AXI_WVALID = 1'b1;
    push(4'h8, 32'h0000_0011, 4'hF);
    drv_edge();
    axi_if.S_AXI_AWADDR = 4'hC; axi_if.S_AXI_WDATA = 32'h0000_0022; axi_if.S_AXI_WSTRB = 4'h5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_bvalid_hold", {31'd0, axi_if.S_AXI_BVALID}, 32'd1);
      check("t4_awready_low", {31'd0, axi_if.S_AXI_AWREADY}, 32'd0);
      check("t4_wready_low", {31'd0, axi_if.S_AXI_WREADY}, 32'd0);
      check("t4_wren", {31'd0, wren}, (i == 0) ? 32'd1 : 32'd0);
      check("t4_awaddr_hold", {28'd0, awaddr_o}, 32'h8);
      if (i < 3) drv_edge();
    end
    drv_edge();
    axi_if.S_AXI_BREADY = 1'b1;
    push(4'hC, 32'h0000_0022, 4'h5);
    @(negedge clk);
    check("t4_bvalid_at_bready", {31'd0, axi_if.S_AXI_BVALID}, 32'd1);
    drv_edge();
    @(negedge clk);
    check("t4_idle_awready", {31'd0, axi_if.S_AXI_AWREADY}, 32'd1);
    check("t4_idle_bvalid", {31'd0, axi_if.S_AXI_BVALID}, 32'd0);
    drv_edge();
    axi_if.S_AXI_AWVALID = 1'b0; axi_if.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    check("t4_second_wren", {31'd0, wren}, 32'd1);
    @(negedge clk);

    // 5: reset while in HAVE_AW
    drv_edge();
    axi_if.S_AXI_AWADDR = 4'h4; axi_if.S_AXI_AWVALID = 1'b1;
    drv_edge();
    axi_if.S_AXI_AWVALID = 1'b0;
    rst = 1'b1;
    axi_if.S_AXI_WDATA = 32'h0000_0099; axi_if.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    check("t5_wready_forced", {31'd0, axi_if.S_AXI_WREADY}, 32'd0);
    drv_edge();
    rst = 1'b0; axi_if.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    check("t5_awaddr", {28'd0, awaddr_o}, 32'd0);
    check("t5_wdata", wdata_o, 32'd0);
    check("t5_wstrb", {28'd0, wstrb_o}, 32'd0);
    check("t5_bvalid", {31'd0, axi_if.S_AXI_BVALID}, 32'd0);
    check("t5_wren", {31'd0, wren}, 32'd0);
    check("t5_idle_wready", {31'd0, axi_if.S_AXI_WREADY}, 32'd1);
    check("t5_idle_awready", {31'd0, axi_if.S_AXI_AWREADY}, 32'd1);
    drv_edge();
    axi_if.S_AXI_AWADDR = 4'h4; axi_if.S_AXI_AWVALID = 1'b1;
    axi_if.S_AXI_WDATA = 32'h0000_005A; axi_if.S_AXI_WSTRB = 4'hF; axi_if.S_AXI_WVALID = 1'b1;
    push(4'h4, 32'h0000_005A, 4'hF);
    drv_edge();
    axi_if.S_AXI_AWVALID = 1'b0; axi_if.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    check("t5_post_wren", {31'd0, wren}, 32'd1);
    @(negedge clk);

    // 6: back-to-back writes, BREADY high
    drv_edge();
    axi_if.S_AXI_AWADDR = 4'h0; axi_if.S_AXI_AWVALID = 1'b1;
    axi_if.S_AXI_WDATA = 32'h0000_0001; axi_if.S_AXI_WSTRB = 4'hF; axi_if.S_AXI_WVALID = 1'b1;
    push(4'h0, 32'h0000_0001, 4'hF);
    drv_edge();
    axi_if.S_AXI_WDATA = 32'h0000_0002;
    push(4'h0, 32'h0000_0002, 4'hF);
    @(negedge clk);
    check("t6_wren1", {31'd0, wren}, 32'd1);
    check("t6_wdata1", wdata_o, 32'h0000_0001);
    @(negedge clk);
    check("t6_gap_wren", {31'd0, wren}, 32'd0);
    check("t6_gap_awready", {31'd0, axi_if.S_AXI_AWREADY}, 32'd1);
    drv_edge();
    axi_if.S_AXI_AWVALID = 1'b0; axi_if.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    check("t6_wren2", {31'd0, wren}, 32'd1);
    check("t6_wdata2", wdata_o, 32'h0000_0002);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    check("wren_count", wren_cnt, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_led_axi_write_ctrl
